// File: rtl/anc_i2s_tx_if.sv
// Controller-side handshake of the I2S output stage.
//   write_output : push strobe from the LMS controller, one clk per sample
//   out_sample   : sample captured when write_output=1
//   start_sample : one-clk frame-start pulse back to the controller
interface anc_i2s_tx_if #(
    parameter int unsigned DATASIZE = 24
);
    logic                write_output;
    logic [DATASIZE-1:0] out_sample;
    logic                start_sample;

    modport master (
        output write_output,
        output out_sample,
        input  start_sample
    );

    modport slave (
        input  write_output,
        input  out_sample,
        output start_sample
    );
endinterface

// File: rtl/anc_i2s_tx.sv
// I2S master transmitter for the noise-canceller output.
// Buffers controller samples in a small FIFO, sends each sample on both
// channels of one I2S frame and paces the controller with start_sample.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = run, 0 = idle (FIFO flushed, outputs quiet)
//   ctl         : controller handshake (write_output, out_sample, start_sample)
//   bclk, lrclk, sdata : I2S bit clock, word select (1 = right), serial data
//   overflow    : one-clk pulse when a push is dropped on a full FIFO
//   underflow   : one-clk pulse when a frame starts with an empty FIFO
//   fifo_level  : current FIFO occupancy
module anc_i2s_tx #(
    parameter int unsigned DATASIZE   = 24,
    parameter int unsigned SLOT       = 32,
    parameter int unsigned BCLK_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    anc_i2s_tx_if.slave                     ctl,
    output logic                            bclk,
    output logic                            lrclk,
    output logic                            sdata,
    output logic                            overflow,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned HALF  = BCLK_DIV / 2;
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BIT_W = $clog2(2 * SLOT);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned IDX_W = (DATASIZE > 1) ? $clog2(DATASIZE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic                bclk_q;
    logic                lrclk_q;
    logic                sdata_q;
    logic [DATASIZE-1:0] hold_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [LVL_W-1:0]    level_d;
    logic                start_q;
    logic                ovf_q;
    logic                unf_q;
    logic [DATASIZE-1:0] mem_q [FIFO_DEPTH];

    logic                run_c;
    logic                fall_c;
    logic                wrap_c;
    logic                pop_c;
    logic                push_c;
    logic                ovf_c;
    logic                unf_c;
    logic                sdata_c;
    logic [BIT_W-1:0]    bit_nxt_c;
    logic [BIT_W-1:0]    pos_c;
    logic [IDX_W-1:0]    idx_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Bit-clock events, slot position of the next bit and FIFO push/pop decisions
    always_comb begin
        run_c     = 1'b0;
        fall_c    = 1'b0;
        wrap_c    = 1'b0;
        pop_c     = 1'b0;
        push_c    = 1'b0;
        ovf_c     = 1'b0;
        unf_c     = 1'b0;
        sdata_c   = 1'b0;
        bit_nxt_c = '0;
        pos_c     = '0;
        idx_c     = '0;
        level_d   = level_q;

        run_c     = (state_q == RUN) && enable;
        fall_c    = run_c && bclk_q && (div_q == DIV_W'(HALF - 1));
        wrap_c    = fall_c && (bit_q == BIT_W'(2 * SLOT - 1));
        bit_nxt_c = wrap_c ? '0 : bit_q + BIT_W'(1);
        pos_c     = (bit_nxt_c >= BIT_W'(SLOT)) ? bit_nxt_c - BIT_W'(SLOT) : bit_nxt_c;
        idx_c     = IDX_W'(DATASIZE - 32'(pos_c));
        // Position 0 is the one-bclk I2S delay slot; MSB goes out at position 1
        if ((pos_c >= BIT_W'(1)) && (pos_c <= BIT_W'(DATASIZE))) begin
            sdata_c = hold_q[idx_c];
        end

        pop_c   = wrap_c && (level_q != '0);
        unf_c   = wrap_c && (level_q == '0);
        // A pop on the same clk frees the slot, so a push into a full FIFO is accepted
        push_c  = run_c && ctl.write_output && ((level_q != LVL_W'(FIFO_DEPTH)) || pop_c);
        ovf_c   = run_c && ctl.write_output && !push_c;
        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
    end

    // Sample storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= ctl.out_sample;
        end
    end

    // Mode FSM, divider, bit counter, FIFO pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            hold_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            start_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (!enable || (state_q == IDLE)) begin
            // Idle, or leaving run: everything quiet and flushed.
            // Entering run is itself a frame start with an empty FIFO.
            state_q  <= enable ? RUN : IDLE;
            start_q  <= enable;
            div_q    <= '0;
            bit_q    <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            hold_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            start_q <= wrap_c;
            ovf_q   <= ovf_c;
            unf_q   <= unf_c;

            if (div_q == DIV_W'(HALF - 1)) begin
                div_q  <= '0;
                bclk_q <= ~bclk_q;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (fall_c) begin
                bit_q   <= bit_nxt_c;
                lrclk_q <= (bit_nxt_c >= BIT_W'(SLOT));
                sdata_q <= sdata_c;
            end

            if (pop_c) begin
                hold_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end else if (unf_c) begin
                hold_q <= '0;
            end

            if (push_c) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end

            level_q <= level_d;
        end
    end

    assign ctl.start_sample = start_q;
    assign bclk             = bclk_q;
    assign lrclk            = lrclk_q;
    assign sdata            = sdata_q;
    assign overflow         = ovf_q;
    assign underflow        = unf_q;
    assign fifo_level       = level_q;

endmodule
